// File: rtl/key_debounce_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : key_debounce_irq_ctrl
// Brief   : Avalon-MM key controller. It synchronises and debounces the
//           active-low keys, captures edges and raises a maskable level IRQ.
//           Define KEY_RELEASE_EDGE_EN to also capture key releases.
// Revision: 1.0 - initial release
// ============================================================================
module key_debounce_irq_ctrl #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [31:0]       readdata,
    output logic              irq
);

`ifdef KEY_RELEASE_EDGE_EN
    localparam int EW = 2 * WIDTH;
`else
    localparam int EW = WIDTH;
`endif

    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] stable_prev_q;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [EW-1:0]    mask_q, mask_d;
    logic [EW-1:0]    edge_q, edge_d;
    logic [EW-1:0]    edge_set;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;
    logic             wr_en;
    logic [WIDTH-1:0] fall, rise;
    logic             unused_wdata;

    assign unused_wdata = ^writedata[31:EW];

    assign wr_en = chipselect & ~write_n;
    assign fall  = stable_prev_q & ~stable_q;
    assign rise  = ~stable_prev_q & stable_q;

`ifdef KEY_RELEASE_EDGE_EN
    assign edge_set = {rise, fall};
`else
    assign edge_set = fall;
    logic unused_rise;
    assign unused_rise = ^rise;
`endif

    // Per-key debounce: a new level is accepted only after DEBOUNCE_CYCLES
    // consecutive cycles of disagreement with the current stable level.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == TERM_CNT) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        mask_d = mask_q;
        edge_d = edge_q;
        if (wr_en && address == 2'd1) begin
            mask_d = writedata[EW-1:0];
        end
        if (wr_en && address == 2'd3) begin
            edge_d = edge_q & ~writedata[EW-1:0];
        end
        // A capture in the same cycle as a clear must survive.
        edge_d = edge_d | edge_set;
        irq_d  = |(edge_q & mask_q);
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            2'd0:    readdata_d[WIDTH-1:0] = stable_q;
            2'd1:    readdata_d[EW-1:0]    = mask_q;
            2'd3:    readdata_d[EW-1:0]    = edge_q;
            default: readdata_d            = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q       <= '1;
            sync2_q       <= '1;
            stable_q      <= '1;
            stable_prev_q <= '1;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            mask_q        <= '0;
            edge_q        <= '0;
            readdata_q    <= '0;
            irq_q         <= 1'b0;
        end else begin
            sync1_q       <= in_port;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            mask_q        <= mask_d;
            edge_q        <= edge_d;
            readdata_q    <= readdata_d;
            irq_q         <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_key_debounce_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_key_debounce_irq_ctrl
// Brief   : Directed bench for key_debounce_irq_ctrl (DEBOUNCE_CYCLES=8).
// Revision: 1.0 - initial release
// ============================================================================
module tb_key_debounce_irq_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [1:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int total = 0;
    int bad   = 0;

`ifdef KEY_RELEASE_EDGE_EN
    localparam logic [31:0] REG_ALL = 32'hF;
`else
    localparam logic [31:0] REG_ALL = 32'h3;
`endif

    typedef struct {
        string       tag;
        bit          is_irq;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    key_debounce_irq_ctrl #(
        .WIDTH          (2),
        .DEBOUNCE_CYCLES(8),
        .CNT_W          (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .in_port   (in_port),
        .readdata  (readdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic exp_rd(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.is_irq = 1'b0; e.val = v;
        sb.push_back(e);
    endtask

    task automatic exp_irq(input string tag, input logic v);
        exp_t e;
        e.tag = tag; e.is_irq = 1'b1; e.val = {31'b0, v};
        sb.push_back(e);
    endtask

    // Advance one clock edge, then check every queued expectation.
    task automatic step();
        exp_t        e;
        logic [31:0] obs;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = e.is_irq ? {31'b0, irq} : readdata;
            total++;
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        reset_n    = 1'b0;
        in_port    = 2'b00;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;

        // Reset state, then both held keys are debounced into presses
        for (int n = 0; n < 3; n++) begin
            exp_rd("rst_rd", 32'h0);
            exp_irq("rst_irq", 1'b0);
            step();
        end
        reset_n = 1'b1;
        for (int n = 1; n <= 11; n++) begin
            exp_rd("post_rst_data", (n <= 10) ? 32'h3 : 32'h0);
            step();
        end

        in_port = 2'b11;
        address = 2'd3;
        repeat (14) step();
        exp_rd("rst_press_ec", REG_ALL);
        exp_irq("rst_press_irq", 1'b0);
        step();
        wr(2'd3, 32'hF);
        address = 2'd0;
        exp_rd("released_data", 32'h3);
        step();
        address = 2'd3;
        exp_rd("ec_cleared", 32'h0);
        step();

        // Mask width and reserved address
        wr(2'd1, 32'hFFFF_FFFF);
        address = 2'd1;
        exp_rd("mask_width", REG_ALL);
        exp_irq("mask_no_ec_irq", 1'b0);
        step();
        wr(2'd2, 32'hFFFF_FFFF);
        address = 2'd2;
        exp_rd("reserved", 32'h0);
        step();
        wr(2'd1, 32'h0);

        // Clean press of key0
        wr(2'd1, 32'h1);
        address = 2'd3;
        in_port = 2'b10;
        for (int n = 1; n <= 12; n++) begin
            if (n >= 10) begin
                exp_rd("press_ec", (n == 12) ? 32'h1 : 32'h0);
                exp_irq("press_irq", n == 12);
            end
            step();
        end
        exp_irq("irq_at_w1c", 1'b1);
        wr(2'd3, 32'h1);
        address = 2'd3;
        exp_irq("irq_drop", 1'b0);
        exp_rd("ec_w1c", 32'h0);
        step();

        // Bounce rejection
        in_port = 2'b11;
        repeat (12) step();
        wr(2'd3, 32'hF);
        address = 2'd0;
        for (int c = 0; c < 40; c++) begin
            in_port[0] = ((c / 3) % 2 == 0) ? 1'b0 : 1'b1;
            exp_rd("bounce_data", 32'h3);
            step();
        end
        in_port = 2'b11;
        for (int c = 0; c < 12; c++) begin
            exp_rd("bounce_settle", 32'h3);
            step();
        end
        address = 2'd3;
        exp_rd("bounce_ec", 32'h0);
        exp_irq("bounce_irq", 1'b0);
        step();

        // Masked press of key1, then unmask
        wr(2'd1, 32'h0);
        address = 2'd3;
        in_port = 2'b01;
        repeat (14) step();
        exp_rd("masked_ec", 32'h2);
        exp_irq("masked_irq", 1'b0);
        step();
        exp_irq("unmask_w0", 1'b0);
        wr(2'd1, 32'h2);
        exp_irq("unmask_w1", 1'b1);
        step();

        // Capture and W1C on the same edge
        in_port = 2'b11;
        repeat (12) step();
        wr(2'd3, 32'hF);
        wr(2'd1, 32'h0);
        address = 2'd3;
        in_port = 2'b10;
        repeat (10) step();
        wr(2'd3, 32'h1);
        address = 2'd3;
        exp_rd("set_wins", 32'h1);
        step();
        wr(2'd3, 32'h1);
        address = 2'd3;
        exp_rd("after_set_wins", 32'h0);
        step();

`ifdef KEY_RELEASE_EDGE_EN
        // Release edges
        in_port = 2'b11;
        repeat (12) step();
        wr(2'd3, 32'hF);
        wr(2'd1, 32'h4);
        address = 2'd3;
        in_port = 2'b10;
        repeat (13) step();
        exp_rd("rel_press_ec", 32'h1);
        exp_irq("rel_press_irq", 1'b0);
        step();
        in_port = 2'b11;
        repeat (12) step();
        exp_rd("rel_release_ec", 32'h5);
        exp_irq("rel_release_irq", 1'b1);
        step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
